// File: rtl/wb_interconnect_nport.sv
// Single-master Wishbone fan-out to NUM_SLAVES ports, decoded on i_m_adr[31:SEL_LSB].
// Registered ack/err/data toward the master, with slave timeout and decode-error handling.
module wb_interconnect_nport #(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned SEL_LSB        = 24,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_m_we,
    input  logic                       i_m_cyc,
    input  logic                       i_m_stb,
    input  logic [31:0]                i_m_adr,
    input  logic [31:0]                i_m_dat,
    output logic                       o_m_ack,
    output logic                       o_m_err,
    output logic [31:0]                o_m_dat,
    output logic                       o_m_int,
    output logic [NUM_SLAVES-1:0]      o_m_int_vec,
    output logic [NUM_SLAVES-1:0]      o_s_we,
    output logic [NUM_SLAVES-1:0]      o_s_cyc,
    output logic [NUM_SLAVES-1:0]      o_s_stb,
    output logic [32*NUM_SLAVES-1:0]   o_s_adr,
    output logic [32*NUM_SLAVES-1:0]   o_s_dat,
    input  logic [NUM_SLAVES-1:0]      i_s_ack,
    input  logic [NUM_SLAVES-1:0]      i_s_int,
    input  logic [32*NUM_SLAVES-1:0]   i_s_dat
);
    localparam int unsigned SelW = 32 - SEL_LSB;
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                state_q, state_d;
    logic [SelW-1:0]       sel_q, sel_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [31:0]           dat_q, dat_d;
    logic [NUM_SLAVES-1:0] int_vec_q;

    logic [SelW-1:0]       req_sel;
    logic [NUM_SLAVES-1:0] hit;
    logic [31:0]           sel_dat;
    logic                  sel_ack;
    logic                  busy;
    logic                  tmo_expire;

    assign req_sel = i_m_adr[31:SEL_LSB];
    assign busy    = (state_q == StBusy);

    // sel_q is only ever in range while busy, so hit is one-hot there.
    always_comb begin
        hit     = '0;
        sel_dat = '0;
        for (int n = 0; n < NUM_SLAVES; n++) begin
            hit[n]  = (32'(sel_q) == 32'(n));
            sel_dat = sel_dat | ({32{hit[n]}} & i_s_dat[32*n +: 32]);
        end
    end

    assign sel_ack    = |(hit & i_s_ack);
    assign tmo_expire = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        dat_d   = dat_q;
        case (state_q)
            StIdle: begin
                if (i_m_cyc && i_m_stb) begin
                    sel_d = req_sel;
                    cnt_d = '0;
                    if (32'(req_sel) < NUM_SLAVES) begin
                        state_d = StBusy;
                    end else begin
                        state_d = StDone;
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        dat_d   = '0;
                    end
                end
            end
            StBusy: begin
                // Abort beats ack; ack in the expiry cycle beats timeout.
                if (!i_m_cyc) begin
                    state_d = StIdle;
                end else if (sel_ack) begin
                    state_d = StDone;
                    ack_d   = 1'b1;
                    dat_d   = sel_dat;
                end else if (tmo_expire) begin
                    state_d = StDone;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    dat_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                if (!i_m_stb) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            sel_q     <= '0;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
            int_vec_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
            int_vec_q <= i_s_int;
        end
    end

    assign o_m_ack     = ack_q;
    assign o_m_err     = err_q;
    assign o_m_dat     = dat_q;
    assign o_m_int_vec = int_vec_q;
    assign o_m_int     = |int_vec_q;

    for (genvar n = 0; n < NUM_SLAVES; n++) begin : g_slave
        assign o_s_cyc[n]          = busy & hit[n];
        assign o_s_stb[n]          = busy & hit[n];
        assign o_s_we[n]           = busy & hit[n] & i_m_we;
        assign o_s_adr[32*n +: 32] = {{SelW{1'b0}}, i_m_adr[SEL_LSB-1:0]};
        assign o_s_dat[32*n +: 32] = i_m_dat;
    end

endmodule

// File: tb/tb_wb_interconnect_nport.sv
// Directed bench for wb_interconnect_nport: 4 slaves, select on bits 31:24, 8-cycle timeout.
module tb_wb_interconnect_nport;
    localparam int unsigned NS = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_m_we, i_m_cyc, i_m_stb;
    logic [31:0]     i_m_adr, i_m_dat;
    logic            o_m_ack, o_m_err, o_m_int;
    logic [31:0]     o_m_dat;
    logic [NS-1:0]   o_m_int_vec;
    logic [NS-1:0]   o_s_we, o_s_cyc, o_s_stb;
    logic [32*NS-1:0] o_s_adr, o_s_dat;
    logic [NS-1:0]   i_s_ack, i_s_int;
    logic [32*NS-1:0] i_s_dat;

    int n_cmp = 0;
    int n_err = 0;

    wb_interconnect_nport #(
        .NUM_SLAVES    (NS),
        .SEL_LSB       (24),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_m_we     (i_m_we),
        .i_m_cyc    (i_m_cyc),
        .i_m_stb    (i_m_stb),
        .i_m_adr    (i_m_adr),
        .i_m_dat    (i_m_dat),
        .o_m_ack    (o_m_ack),
        .o_m_err    (o_m_err),
        .o_m_dat    (o_m_dat),
        .o_m_int    (o_m_int),
        .o_m_int_vec(o_m_int_vec),
        .o_s_we     (o_s_we),
        .o_s_cyc    (o_s_cyc),
        .o_s_stb    (o_s_stb),
        .o_s_adr    (o_s_adr),
        .o_s_dat    (o_s_dat),
        .i_s_ack    (i_s_ack),
        .i_s_int    (i_s_int),
        .i_s_dat    (i_s_dat)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic we, input logic [31:0] adr, input logic [31:0] dat);
        i_m_we  = we;
        i_m_adr = adr;
        i_m_dat = dat;
        i_m_cyc = 1'b1;
        i_m_stb = 1'b1;
    endtask

    task automatic drop();
        i_m_cyc = 1'b0;
        i_m_stb = 1'b0;
        i_m_we  = 1'b0;
        i_s_ack = '0;
    endtask

    initial begin
        rst = 1'b1;
        i_m_we = 1'b0; i_m_cyc = 1'b0; i_m_stb = 1'b0;
        i_m_adr = '0; i_m_dat = '0;
        i_s_ack = '0; i_s_int = '0; i_s_dat = '0;
        tick();
        tick();
        chk("rst_ack", 32'(o_m_ack), 32'd0);
        chk("rst_stb", 32'(o_s_stb), 32'd0);
        chk("rst_dat", o_m_dat, 32'd0);
        chk("rst_ivec", 32'(o_m_int_vec), 32'd0);
        rst = 1'b0;

        // Read from slave 2, stray ack from slave 1 first, real ack on the third busy cycle
        req(1'b0, 32'h0200_0010, 32'h0);
        tick();
        chk("rd_stb", 32'(o_s_stb), 32'h4);
        chk("rd_cyc", 32'(o_s_cyc), 32'h4);
        chk("rd_we", 32'(o_s_we), 32'h0);
        chk("rd_adr2", o_s_adr[64 +: 32], 32'h0000_0010);
        i_s_ack = 4'b0010;
        i_s_dat[32 +: 32] = 32'hDEAD_0001;
        tick();
        chk("rd_stray_ack", 32'(o_m_ack), 32'd0);
        chk("rd_stb_hold", 32'(o_s_stb), 32'h4);
        i_s_ack = '0;
        tick();
        i_s_ack = 4'b0100;
        i_s_dat[64 +: 32] = 32'hCAFE_F00D;
        tick();
        chk("rd_ack", 32'(o_m_ack), 32'd1);
        chk("rd_err", 32'(o_m_err), 32'd0);
        chk("rd_dat", o_m_dat, 32'hCAFE_F00D);
        chk("rd_stb_off", 32'(o_s_stb), 32'h0);
        drop();
        tick();
        chk("rd_ack_pulse", 32'(o_m_ack), 32'd0);
        chk("rd_dat_hold", o_m_dat, 32'hCAFE_F00D);

        // Write to slave 1, stb held across DONE must not re-issue
        req(1'b1, 32'h0100_0004, 32'h1234_5678);
        tick();
        chk("wr_we", 32'(o_s_we), 32'h2);
        chk("wr_dat1", o_s_dat[32 +: 32], 32'h1234_5678);
        chk("wr_adr1", o_s_adr[32 +: 32], 32'h0000_0004);
        i_s_ack = 4'b0010;
        i_s_dat[32 +: 32] = 32'hAAAA_5555;
        tick();
        chk("wr_ack", 32'(o_m_ack), 32'd1);
        chk("wr_err", 32'(o_m_err), 32'd0);
        chk("wr_dat", o_m_dat, 32'hAAAA_5555);
        i_s_ack = '0;
        tick();
        chk("wr_ack_once", 32'(o_m_ack), 32'd0);
        chk("wr_no_reissue", 32'(o_s_stb), 32'h0);
        tick();
        chk("wr_no_reissue2", 32'(o_s_stb), 32'h0);
        drop();
        tick();

        // Decode error: slave 5 does not exist
        req(1'b0, 32'h0500_0000, 32'h0);
        #1;
        chk("de_stb_pre", 32'(o_s_stb), 32'h0);
        tick();
        chk("de_ack", 32'(o_m_ack), 32'd1);
        chk("de_err", 32'(o_m_err), 32'd1);
        chk("de_dat", o_m_dat, 32'h0);
        chk("de_stb", 32'(o_s_stb), 32'h0);
        drop();
        tick();
        chk("de_ack_off", 32'(o_m_ack), 32'd0);
        chk("de_err_off", 32'(o_m_err), 32'd0);

        // Timeout on slave 0 after 8 busy cycles
        req(1'b0, 32'h0000_0000, 32'h0);
        tick();
        for (int i = 0; i < 7; i++) begin
            chk("to_wait_ack", 32'(o_m_ack), 32'd0);
            chk("to_wait_stb", 32'(o_s_stb), 32'h1);
            tick();
        end
        chk("to_c8_stb", 32'(o_s_stb), 32'h1);
        tick();
        chk("to_ack", 32'(o_m_ack), 32'd1);
        chk("to_err", 32'(o_m_err), 32'd1);
        chk("to_dat", o_m_dat, 32'h0);
        chk("to_stb_off", 32'(o_s_stb), 32'h0);
        drop();
        tick();

        // Ack on the 8th busy cycle wins over expiry
        req(1'b0, 32'h0000_0020, 32'h0);
        tick();
        for (int i = 0; i < 7; i++) tick();
        i_s_ack = 4'b0001;
        i_s_dat[0 +: 32] = 32'h5A5A_0008;
        tick();
        chk("to8_ack", 32'(o_m_ack), 32'd1);
        chk("to8_err", 32'(o_m_err), 32'd0);
        chk("to8_dat", o_m_dat, 32'h5A5A_0008);
        drop();
        tick();

        // Interrupt snapshot is one cycle late
        i_s_int = 4'b0100;
        #1;
        chk("int_pre", 32'(o_m_int_vec), 32'h0);
        tick();
        chk("int_vec", 32'(o_m_int_vec), 32'h4);
        chk("int_or", 32'(o_m_int), 32'd1);
        i_s_int = '0;
        tick();
        chk("int_clr", 32'(o_m_int), 32'd0);

        // Master abort in BUSY
        req(1'b0, 32'h0300_0000, 32'h0);
        tick();
        chk("ab_stb", 32'(o_s_stb), 32'h8);
        drop();
        tick();
        chk("ab_stb_off", 32'(o_s_stb), 32'h0);
        chk("ab_no_ack", 32'(o_m_ack), 32'd0);
        tick();
        chk("ab_no_ack2", 32'(o_m_ack), 32'd0);
        chk("ab_dat_hold", o_m_dat, 32'h5A5A_0008);

        // Asynchronous reset in the middle of a transfer
        req(1'b0, 32'h0200_0000, 32'h0);
        i_s_int = 4'b1111;
        tick();
        chk("rb_stb", 32'(o_s_stb), 32'h4);
        chk("rb_ivec", 32'(o_m_int_vec), 32'hF);
        #2;
        rst = 1'b1;
        #1;
        chk("rb_stb_off", 32'(o_s_stb), 32'h0);
        chk("rb_cyc_off", 32'(o_s_cyc), 32'h0);
        chk("rb_dat", o_m_dat, 32'h0);
        chk("rb_ivec_off", 32'(o_m_int_vec), 32'h0);
        chk("rb_int_off", 32'(o_m_int), 32'd0);
        i_s_ack = 4'b0100;
        tick();
        chk("rb_no_ack", 32'(o_m_ack), 32'd0);
        drop();
        i_s_int = '0;
        req(1'b0, 32'h0100_0000, 32'h0);
        rst = 1'b0;
        tick();
        chk("post_rst_accept", 32'(o_s_stb), 32'h2);
        chk("post_rst_no_ack", 32'(o_m_ack), 32'd0);
        i_s_ack = 4'b0010;
        i_s_dat[32 +: 32] = 32'h0000_BEEF;
        tick();
        chk("post_rst_ack", 32'(o_m_ack), 32'd1);
        chk("post_rst_dat", o_m_dat, 32'h0000_BEEF);
        drop();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
